// File: rtl/mmio_store_queue.sv
// mmio_store_queue: FIFO of MMIO-window stores from the MEM stage, drained toward the SPART.
// Optional feature: define SQ_BYPASS_EN for a zero-latency pass-through when the queue is empty.
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset
//   st_en/st_addr/...   store request from the pipeline, held stable while sq_stall=1
//   mmio_hit            store falls inside the MMIO window
//   sq_stall            back-pressure: an MMIO store cannot be accepted this cycle
//   out_valid/out_ready head-entry handshake toward the SPART
//   out_addr/out_data   head entry
//   count/empty         occupancy
module mmio_store_queue #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 32'hFFFF_0000,
    parameter logic [ADDR_W-1:0] MMIO_MASK = 32'hFFFF_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_en,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic [DATA_W-1:0]      st_data,
    output logic                   mmio_hit,
    output logic                   sq_stall,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [PW:0]       r_count;
    logic              w_byp;
    logic              w_pop;
    logic              w_push;
    logic              w_wr;
    logic              w_rd;

    assign mmio_hit = st_en & ((st_addr & MMIO_MASK) == (MMIO_BASE & MMIO_MASK));
`ifdef SQ_BYPASS_EN
    assign w_byp = mmio_hit & (r_count == '0);
`else
    assign w_byp = 1'b0;
`endif
    assign out_valid = (r_count != '0) | w_byp;
    assign out_addr  = w_byp ? st_addr : r_addr[r_rd];
    assign out_data  = w_byp ? st_data : r_data[r_rd];
    assign w_pop     = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts the store.
    assign sq_stall  = mmio_hit & (r_count == FULL) & ~w_pop;
    assign w_push    = mmio_hit & ~sq_stall;
    // A bypassed store that is accepted immediately never touches the buffer.
    assign w_wr      = w_push & ~(w_byp & out_ready);
    assign w_rd      = w_pop & ~w_byp;
    assign count     = r_count;
    assign empty     = (r_count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + PW'(1);
            if (w_rd) r_rd <= r_rd + PW'(1);
            r_count <= r_count + (PW+1)'(w_wr) - (PW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_addr[r_wr] <= st_addr;
            r_data[r_wr] <= st_data;
        end
    end
endmodule

// File: tb/tb_mmio_store_queue.sv
// tb_mmio_store_queue: directed vector table on a DEPTH=4 queue plus randomized queue-model check on DEPTH=8.
module tb_mmio_store_queue;
`ifdef SQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] MASK = 32'hFFFF_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        e4, r4, h4, s4, v4, m4;
    logic [31:0] a4, d4, oa4, od4;
    logic [2:0]  c4;
    logic        e8, r8, h8, s8, v8, m8;
    logic [31:0] a8, d8, oa8, od8;
    logic [3:0]  c8;

    mmio_store_queue #(.DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .st_en(e4), .st_addr(a4), .st_data(d4),
        .mmio_hit(h4), .sq_stall(s4), .out_valid(v4), .out_ready(r4),
        .out_addr(oa4), .out_data(od4), .count(c4), .empty(m4)
    );
    mmio_store_queue #(.DEPTH(8)) u8 (
        .clk(clk), .rst(rst), .st_en(e8), .st_addr(a8), .st_data(d8),
        .mmio_hit(h8), .sq_stall(s8), .out_valid(v8), .out_ready(r8),
        .out_addr(oa8), .out_data(od8), .count(c8), .empty(m8)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
        logic        hit;
        logic        stall;
        logic        vld;
        int          cnt;
        logic [31:0] oaddr;
        logic [31:0] odata;
    } vec_t;

    function automatic vec_t mk(logic en, logic [31:0] addr, logic [31:0] data, logic rdy,
                                logic hit, logic stall, logic vld, int cnt,
                                logic [31:0] oaddr, logic [31:0] odata);
        mk = '{en, addr, data, rdy, hit, stall, vld, cnt, oaddr, odata};
    endfunction

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    vec_t tbl[19];
    ent_t q[$];
    ent_t hd;
    logic pst, hit, byp, vld, pop, stl;

    localparam logic [31:0] A4  = 32'hFFFF_0004;
    localparam logic [31:0] A10 = 32'hFFFF_0010;

    initial begin
        tbl[0]  = mk(0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, A4, 32'h41, 1,       1, 0, BYP, 0, A4, 32'h41);
        tbl[2]  = mk(0, 0, 0, 1,             0, 0, !BYP, BYP ? 0 : 1, A4, 32'h41);
        tbl[3]  = mk(0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 32'h0000_1000, 32'h77, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, A10, 1, 0,           1, 0, BYP, 0, A10, 1);
        tbl[7]  = mk(1, A10, 2, 0,           1, 0, 1, 1, A10, 1);
        tbl[8]  = mk(1, A10, 3, 0,           1, 0, 1, 2, A10, 1);
        tbl[9]  = mk(1, A10, 4, 0,           1, 0, 1, 3, A10, 1);
        tbl[10] = mk(1, A10, 5, 0,           1, 1, 1, 4, A10, 1);
        tbl[11] = mk(1, A10, 5, 0,           1, 1, 1, 4, A10, 1);
        tbl[12] = mk(1, A10, 5, 1,           1, 0, 1, 4, A10, 1);
        tbl[13] = mk(0, 0, 0, 1,             0, 0, 1, 4, A10, 2);
        tbl[14] = mk(0, 0, 0, 1,             0, 0, 1, 3, A10, 3);
        tbl[15] = mk(0, 0, 0, 1,             0, 0, 1, 2, A10, 4);
        tbl[16] = mk(0, 0, 0, 1,             0, 0, 1, 1, A10, 5);
        tbl[17] = mk(0, 0, 0, 1,             0, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0,             0, 0, 0, 0, 0, 0);

        rst = 1'b0;
        {e4, a4, d4, r4} = '0;
        {e8, a8, d8, r8} = '0;
        #1;
        chk("reset valid", 32'(v4), 0);
        chk("reset empty", 32'(m4), 1);
        chk("reset count", 32'(c4), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            e4 = tbl[i].en; a4 = tbl[i].addr; d4 = tbl[i].data; r4 = tbl[i].rdy;
            #2;
            chk($sformatf("row%0d hit", i),   32'(h4), 32'(tbl[i].hit));
            chk($sformatf("row%0d stall", i), 32'(s4), 32'(tbl[i].stall));
            chk($sformatf("row%0d valid", i), 32'(v4), 32'(tbl[i].vld));
            chk($sformatf("row%0d count", i), 32'(c4), 32'(tbl[i].cnt));
            chk($sformatf("row%0d empty", i), 32'(m4), 32'(tbl[i].cnt == 0));
            if (tbl[i].vld) begin
                chk($sformatf("row%0d addr", i), oa4, tbl[i].oaddr);
                chk($sformatf("row%0d data", i), od4, tbl[i].odata);
            end
            @(posedge clk);
            #1;
        end

        // Fill four entries, drain one, then reset asynchronously mid-drain.
        for (int i = 0; i < 4; i++) begin
            e4 = 1; a4 = A10; d4 = 32'hA0 + 32'(i); r4 = 0;
            @(posedge clk);
            #1;
        end
        e4 = 0; r4 = 1;
        @(posedge clk);
        #1;
        chk("middrain count", 32'(c4), 3);
        chk("middrain head", od4, 32'hA1);
        #2 rst = 1'b0;
        #1;
        chk("async rst valid", 32'(v4), 0);
        chk("async rst empty", 32'(m4), 1);
        chk("async rst count", 32'(c4), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        r4 = 0;

        // Randomized interleaving on the DEPTH=8 instance against a queue model.
        pst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pst) begin
                e8 = $urandom_range(0, 9) < 7;
                a8 = (($urandom_range(0, 4) == 0) ? 32'h0000_0000 : 32'hFFFF_0000) | ($urandom & 32'h0000_FFFF);
                d8 = $urandom;
            end
            r8 = $urandom_range(0, 9) < 4;
            #2;
            hit = e8 && ((a8 & MASK) == (BASE & MASK));
            byp = BYP && q.size() == 0 && hit;
            vld = q.size() != 0 || byp;
            hd  = byp ? {a8, d8} : (q.size() != 0 ? q[0] : '0);
            pop = vld && r8;
            stl = hit && q.size() == 8 && !pop;
            chk("rnd hit", 32'(h8), 32'(hit));
            chk("rnd stall", 32'(s8), 32'(stl));
            chk("rnd valid", 32'(v8), 32'(vld));
            chk("rnd count", 32'(c8), 32'(q.size()));
            chk("rnd empty", 32'(m8), 32'(q.size() == 0));
            if (vld) begin
                chk("rnd addr", oa8, hd.a);
                chk("rnd data", od8, hd.d);
            end
            @(posedge clk);
            if (pop && !byp) void'(q.pop_front());
            if (hit && !stl && !(byp && r8)) q.push_back({a8, d8});
            pst = stl;
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mmio_store_queue.md
MMIO_STORE_QUEUE -- requirements
Module: mmio_store_queue

Interface
REQ-001 Parameter DATA_W, default 32, store data width.
REQ-002 Parameter ADDR_W, default 32, store address width.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, 2..64.
REQ-004 Parameter MMIO_BASE, default 32'hFFFF_0000, MMIO window base address.
REQ-005 Parameter MMIO_MASK, default 32'hFFFF_0000, address bits compared against MMIO_BASE.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 st_en  in  1  store request from the MEM stage.
REQ-009 st_addr  in  ADDR_W  store address.
REQ-010 st_data  in  DATA_W  store data.
REQ-011 mmio_hit  out  1  combinational: st_en and (st_addr & MMIO_MASK) == (MMIO_BASE & MMIO_MASK).
REQ-012 sq_stall  out  1  combinational back-pressure to the pipeline.
REQ-013 out_valid  out  1  head entry valid toward the SPART.
REQ-014 out_ready  in  1  SPART accepts the head entry.
REQ-015 out_addr  out  ADDR_W  head entry address.
REQ-016 out_data  out  DATA_W  head entry data.
REQ-017 count  out  clog2(DEPTH)+1  current occupancy.
REQ-018 empty  out  1  count == 0.

Function
REQ-019 Only stores with mmio_hit=1 are enqueued; non-hit stores are ignored and never stall.
REQ-020 Circular buffer: write pointer and read pointer, each clog2(DEPTH) bits, wrap from DEPTH-1 to 0.
REQ-021 pop = out_valid & out_ready; push = mmio_hit & ~sq_stall.
REQ-022 sq_stall = mmio_hit & (count == DEPTH) & ~pop; a push while full is accepted if a pop occurs in the same cycle.
REQ-023 While sq_stall=1, the pipeline holds st_en/st_addr/st_data stable; the block neither drops nor duplicates the store.
REQ-024 Push and pop in the same cycle leave count unchanged; push only: count+1; pop only: count-1.
REQ-025 Entries leave in strict FIFO order.
REQ-026 out_valid = (count != 0), except as modified by REQ-031.
REQ-027 out_addr/out_data are the head entry and are stable while out_valid=1 and out_ready=0.
REQ-028 out_ready while out_valid=0 has no effect; count never underflows and never exceeds DEPTH.
REQ-029 Without bypass, latency from push to out_valid is 1 cycle.

Reset
REQ-030 On rst low, immediately: pointers=0, count=0, empty=1, out_valid=0. All entries are discarded, including a reset mid-drain. Stored data contents are don't-care.

Configuration
REQ-031 Macro SQ_BYPASS_EN, when defined:
- If count==0 and mmio_hit=1, out_valid=1 combinationally, with out_addr=st_addr and out_data=st_data.
- If out_ready=1 in that cycle, the store completes with zero latency and is not written to the buffer (count stays 0).
- If out_ready=0, the store is enqueued normally.
REQ-032 Without SQ_BYPASS_EN, outputs come only from buffer entries and REQ-029 applies.

Verification
REQ-033 Reset, then st_en=1, st_addr=32'hFFFF_0004, st_data=32'h41, out_ready=1 -> no bypass: out_valid on the next cycle with data 32'h41, count returns to 0; with SQ_BYPASS_EN: out_valid in the same cycle, count stays 0.
REQ-034 Five consecutive hit stores, data 1..5, out_ready=0, DEPTH=4 -> count=4 after four cycles; sq_stall=1 on the fifth; after out_ready pulses, data drains in order 1,2,3,4,5 and none are lost.
REQ-035 Full queue, hit store and out_ready=1 in the same cycle -> sq_stall=0, count stays 4, head advances.
REQ-036 Store to 32'h0000_1000 -> mmio_hit=0, sq_stall=0, count unchanged.
REQ-037 DEPTH=8: 20 push/pop interleavings crossing pointer wrap -> output order matches a scoreboard and count matches a reference model.
REQ-038 rst asserted asynchronously with count=3 mid-drain -> out_valid=0 and empty=1 before the next clk edge.
